// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-register hazard signals shared by the pipeline and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              ResultSrcE, PCSrcE, MemReqM, MemAckM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE;
  logic [CNT_W-1:0]  StallCnt, FlushCnt, FwdCnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
    input  StallCnt, FlushCnt, FwdCnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
    output StallCnt, FlushCnt, FwdCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use bubbles, memory freeze and branch flush for the 5-stage pipeline
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [2:0] BUB_INIT = 3'(LOAD_BUBBLES - 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t            state;
  logic [2:0]        bub_cnt;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]        fwd_a, fwd_b;
  logic              lu_hit, mem_wait, br_flush;
  logic              stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

  assign rs1_d = hz.Rs1_D;
  assign rs2_d = hz.Rs2_D;
  assign rs1_e = hz.Rs1_E;
  assign rs2_e = hz.Rs2_E;
  assign rd_e  = hz.RD_E;
  assign rd_m  = hz.RD_M;
  assign rd_w  = hz.RD_W;

  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && rd_m != '0 && rd_m == rs1_e)      fwd_a = 2'b10;
    else if (hz.RegWriteW && rd_w != '0 && rd_w == rs1_e) fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (hz.RegWriteM && rd_m != '0 && rd_m == rs2_e)      fwd_b = 2'b10;
    else if (hz.RegWriteW && rd_w != '0 && rd_w == rs2_e) fwd_b = 2'b01;
  end

  assign lu_hit   = hz.ResultSrcE && hz.RegWriteE && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
  assign mem_wait = hz.MemReqM && !hz.MemAckM;

  // Stall/flush depend on the current cycle's inputs so the first bubble lands in the detection cycle.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    br_flush = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        end else if (hz.PCSrcE) begin
          flush_d  = 1'b1;
          flush_e  = 1'b1;
          br_flush = 1'b1;
        end else if (lu_hit) begin
          {stall_f, stall_d, flush_e} = 3'b111;
        end
      end
      LU_STALL: begin
        if (mem_wait) {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        else          {stall_f, stall_d, flush_e} = 3'b111;
      end
      MEM_WAIT: {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state <= MEM_WAIT;
          end else if (!hz.PCSrcE && lu_hit) begin
            bub_cnt <= BUB_INIT;
            if (BUB_INIT != 3'd0) state <= LU_STALL;
          end
        end
        LU_STALL: begin
          // bub_cnt stays frozen across a memory wait and resumes afterwards.
          if (mem_wait) begin
            state <= MEM_WAIT;
          end else if (bub_cnt <= 3'd1) begin
            bub_cnt <= 3'd0;
            state   <= RUN;
          end else begin
            bub_cnt <= bub_cnt - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (hz.MemAckM) state <= (bub_cnt != 3'd0) ? LU_STALL : RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign hz.ForwardAE = rst ? 2'b00 : fwd_a;
  assign hz.ForwardBE = rst ? 2'b00 : fwd_b;
  assign hz.StallF    = stall_f & ~rst;
  assign hz.StallD    = stall_d & ~rst;
  assign hz.StallE    = stall_e & ~rst;
  assign hz.StallM    = stall_m & ~rst;
  assign hz.FlushD    = flush_d & ~rst;
  assign hz.FlushE    = flush_e & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_f)                          stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_flush)                         flush_cnt <= flush_cnt + CNT_W'(1);
      if (fwd_a != 2'b00 || fwd_b != 2'b00) fwd_cnt   <= fwd_cnt + CNT_W'(1);
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
  assign hz.FwdCnt   = fwd_cnt;
`else
  assign hz.StallCnt = CNT_W'(0);
  assign hz.FlushCnt = CNT_W'(0);
  assign hz.FwdCnt   = CNT_W'(0);
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl (LOAD_BUBBLES=3/CNT_W=4 and LOAD_BUBBLES=2/CNT_W=32)
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  ifa ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) ifb ();

  hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(3), .CNT_W(4))  dut_a (.clk(clk), .rst(rst_a), .hz(ifa.slave));
  hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(2), .CNT_W(32)) dut_b (.clk(clk), .rst(rst_b), .hz(ifb.slave));

  typedef struct {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [6:0] ctl;  // {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM}
    logic [1:0] fa, fb;
    logic [3:0] stl;  // {StallF, StallD, StallE, StallM}
    logic [1:0] fl;   // {FlushD, FlushE}
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  int n_cmp = 0;
  int n_err = 0;
  longint unsigned m_s[2], m_f[2], m_w[2];

  function automatic vec_t mk(logic r, logic [4:0] rs1d, logic [4:0] rs2d, logic [4:0] rs1e,
                              logic [4:0] rs2e, logic [4:0] rde, logic [4:0] rdm, logic [4:0] rdw,
                              logic [6:0] ctl, logic [1:0] fa, logic [1:0] fb,
                              logic [3:0] stl, logic [1:0] fl);
    vec_t v;
    v.rst = r; v.rs1_d = rs1d; v.rs2_d = rs2d; v.rs1_e = rs1e; v.rs2_e = rs2e;
    v.rd_e = rde; v.rd_m = rdm; v.rd_w = rdw; v.ctl = ctl;
    v.fa = fa; v.fb = fb; v.stl = stl; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit b);
    if (!b) begin
      rst_a = v.rst;
      ifa.Rs1_D = v.rs1_d; ifa.Rs2_D = v.rs2_d; ifa.Rs1_E = v.rs1_e; ifa.Rs2_E = v.rs2_e;
      ifa.RD_E = v.rd_e; ifa.RD_M = v.rd_m; ifa.RD_W = v.rd_w;
      {ifa.RegWriteE, ifa.RegWriteM, ifa.RegWriteW, ifa.ResultSrcE,
       ifa.PCSrcE, ifa.MemReqM, ifa.MemAckM} = v.ctl;
    end else begin
      rst_b = v.rst;
      ifb.Rs1_D = v.rs1_d; ifb.Rs2_D = v.rs2_d; ifb.Rs1_E = v.rs1_e; ifb.Rs2_E = v.rs2_e;
      ifb.RD_E = v.rd_e; ifb.RD_M = v.rd_m; ifb.RD_W = v.rd_w;
      {ifb.RegWriteE, ifb.RegWriteM, ifb.RegWriteW, ifb.ResultSrcE,
       ifb.PCSrcE, ifb.MemReqM, ifb.MemAckM} = v.ctl;
    end
  endtask

  // One cycle: drive after the rising edge, compare at the falling edge, then advance the counter model.
  task automatic run(input vec_t v, input bit b, input string tag);
    logic [1:0]  fa, fb, fl;
    logic [3:0]  stl;
    logic [31:0] sc, fc, wc;
    longint unsigned mask;
    @(posedge clk);
    #1;
    drive(v, b);
    @(negedge clk);
    if (!b) begin
      fa = ifa.ForwardAE; fb = ifa.ForwardBE;
      stl = {ifa.StallF, ifa.StallD, ifa.StallE, ifa.StallM};
      fl = {ifa.FlushD, ifa.FlushE};
      sc = 32'(ifa.StallCnt); fc = 32'(ifa.FlushCnt); wc = 32'(ifa.FwdCnt);
      mask = 64'hF;
    end else begin
      fa = ifb.ForwardAE; fb = ifb.ForwardBE;
      stl = {ifb.StallF, ifb.StallD, ifb.StallE, ifb.StallM};
      fl = {ifb.FlushD, ifb.FlushE};
      sc = ifb.StallCnt; fc = ifb.FlushCnt; wc = ifb.FwdCnt;
      mask = 64'hFFFF_FFFF;
    end
    chk({tag, " fwd_a"}, 32'(fa), 32'(v.fa));
    chk({tag, " fwd_b"}, 32'(fb), 32'(v.fb));
    chk({tag, " stalls"}, 32'(stl), 32'(v.stl));
    chk({tag, " flushes"}, 32'(fl), 32'(v.fl));
    chk({tag, " stall_cnt"}, sc, 32'(m_s[b] & mask));
    chk({tag, " flush_cnt"}, fc, 32'(m_f[b] & mask));
    chk({tag, " fwd_cnt"}, wc, 32'(m_w[b] & mask));
    if (v.rst) begin
      m_s[b] = 0; m_f[b] = 0; m_w[b] = 0;
    end else if (PERF) begin
      if (v.stl[3]) m_s[b]++;
      if (v.fl[1]) m_f[b]++;
      if (v.fa != 2'b00 || v.fb != 2'b00) m_w[b]++;
    end
  endtask

  initial begin
    // A: LOAD_BUBBLES=3, CNT_W=4
    tab_a.push_back(mk(1, 7,0, 5,0, 7,5,0, 7'b1101000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 5,0, 0,5,5, 7'b0110000, 2'd2,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 5,0, 0,5,5, 7'b0010000, 2'd1,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 5,0, 0,0,0, 7'b0110000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 3,9, 0,3,9, 7'b0110000, 2'd2,2'd1, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0110000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,7, 0,0, 7,0,0, 7'b1001000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_a.push_back(mk(0, 0,7, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_a.push_back(mk(0, 0,7, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b1001000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 7,0, 0,0, 7,0,0, 7'b1000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 7,0, 0,0, 7,0,0, 7'b1001100, 2'd0,2'd0, 4'b0000,2'b11));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000010, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,0, 5,0, 0,0,5, 7'b0010010, 2'd1,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000011, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000011, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000110, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000001, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000010, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(1, 0,0, 0,0, 0,0,0, 7'b0000010, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_a.push_back(mk(0, 0,7, 0,0, 7,0,0, 7'b1001010, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,7, 0,0, 7,0,0, 7'b1001001, 2'd0,2'd0, 4'b1111,2'b00));
    tab_a.push_back(mk(0, 0,7, 0,0, 7,0,0, 7'b1001000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_a.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));

    // B: LOAD_BUBBLES=2, memory wait starting in the second bubble
    tab_b.push_back(mk(1, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));
    tab_b.push_back(mk(0, 0,7, 0,0, 7,0,0, 7'b1001000, 2'd0,2'd0, 4'b1100,2'b01));
    for (int k = 0; k < 4; k++)
      tab_b.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000010, 2'd0,2'd0, 4'b1111,2'b00));
    tab_b.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000001, 2'd0,2'd0, 4'b1111,2'b00));
    tab_b.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b1100,2'b01));
    tab_b.push_back(mk(0, 0,0, 0,0, 0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00));

    for (int k = 0; k < 2; k++) begin
      m_s[k] = 0; m_f[k] = 0; m_w[k] = 0;
    end
    drive(mk(1, 0,0,0,0,0,0,0, 7'b0, 2'd0,2'd0, 4'b0,2'b0), 1'b0);
    drive(mk(1, 0,0,0,0,0,0,0, 7'b0, 2'd0,2'd0, 4'b0,2'b0), 1'b1);
    repeat (3) @(posedge clk);

    foreach (tab_a[i]) run(tab_a[i], 1'b0, $sformatf("A[%0d]", i));
    foreach (tab_b[i]) run(tab_b[i], 1'b1, $sformatf("B[%0d]", i));
    chk("B total stall_cnt", ifb.StallCnt, PERF ? 32'd7 : 32'd0);
    chk("B total flush_cnt", ifb.FlushCnt, 32'd0);

    // 17 consecutive stall cycles wrap the 4-bit counter to 1.
    run(mk(1, 0,0,0,0,0,0,0, 7'b0, 2'd0,2'd0, 4'b0000,2'b00), 1'b0, "wrap rst");
    for (int k = 0; k < 16; k++)
      run(mk(0, 0,0,0,0,0,0,0, 7'b0000010, 2'd0,2'd0, 4'b1111,2'b00), 1'b0, $sformatf("wrap[%0d]", k));
    run(mk(0, 0,0,0,0,0,0,0, 7'b0000001, 2'd0,2'd0, 4'b1111,2'b00), 1'b0, "wrap ack");
    run(mk(0, 0,0,0,0,0,0,0, 7'b0000000, 2'd0,2'd0, 4'b0000,2'b00), 1'b0, "wrap idle");
    chk("wrap stall_cnt", 32'(ifa.StallCnt), PERF ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage RISC-V pipeline. It replaces the purely combinational forwarding unit with a block that does four things: resolves operand forwarding for execute, inserts multi-cycle load-use bubbles, freezes the pipeline while data memory is busy, and flushes wrong-path instructions on taken branches. It sits beside the stage modules in `pipeline_top`, reads register addresses and control bits from the D/E/M/W pipeline registers, and drives their stall and flush inputs.

## Interface
- `REG_AW`, 5: register-address width; address 0 is hard-wired zero and is never forwarded or stalled on.
- `LOAD_BUBBLES`, 1: bubbles inserted per load-use hazard; range 1..7.
- `CNT_W`, 32: width of each performance counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `Rs1_D`, `Rs2_D`  in  REG_AW  source registers of the instruction in decode.
- `Rs1_E`, `Rs2_E`  in  REG_AW  source registers of the instruction in execute.
- `RD_E`, `RD_M`, `RD_W`  in  REG_AW  destination registers in E, M and W.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1  register-write enables per stage.
- `ResultSrcE`  in  1  instruction in E is a load.
- `PCSrcE`  in  1  taken branch or jump resolved in E.
- `MemReqM`  in  1  data-memory access active in M.
- `MemAckM`  in  1  data memory completes the access this cycle.
- `ForwardAE`, `ForwardBE`  out  2  operand select: 00 = register file, 01 = ResultW, 10 = ALU_ResultM.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1  hold the corresponding pipeline register.
- `FlushD`, `FlushE`  out  1  clear the corresponding pipeline register to a bubble.
- `StallCnt`, `FlushCnt`, `FwdCnt`  out  CNT_W  performance counters.

## Operation
- **Forwarding** (combinational). For operand A:
  - If `RegWriteM` and `RD_M` != 0 and `RD_M` == `Rs1_E`, select 10.
  - Else if `RegWriteW` and `RD_W` != 0 and `RD_W` == `Rs1_E`, select 01.
  - Else select 00.
  - Operand B is identical, using `Rs2_E`. M takes priority over W.
- **Load-use hazard** (`lu_hit`): `ResultSrcE` and `RegWriteE` and `RD_E` != 0 and `RD_E` matches `Rs1_D` or `Rs2_D`.
- **FSM states:**
  - **RUN**
    - `MemReqM` and not `MemAckM`: assert `StallF`, `StallD`, `StallE`, `StallM`; go to MEM_WAIT.
    - Else `PCSrcE`: assert `FlushD` and `FlushE`; stay in RUN. A branch cancels any `lu_hit`, because the instruction in D is on the wrong path.
    - Else `lu_hit`: assert `StallF`, `StallD`, `FlushE`; load `bub_cnt` = `LOAD_BUBBLES`-1. Go to LU_STALL if `bub_cnt` is nonzero, otherwise stay in RUN.
  - **LU_STALL**
    - Assert `StallF`, `StallD`, `FlushE`; decrement `bub_cnt`.
    - Return to RUN when `bub_cnt` reaches 0.
    - Memory wait takes precedence: freeze `bub_cnt` and assert the MEM_WAIT outputs.
  - **MEM_WAIT**
    - Hold all four stalls and no flushes until the cycle in which `MemAckM` = 1. In that cycle the stalls are still asserted.
    - Next state is RUN, or the frozen LU_STALL if `bub_cnt` is nonzero.
- **Priority:** memory wait > branch flush > load-use.
- **Forwarding during stalls:** forwarding outputs remain valid and combinational during stalls.
- **Counters:**
  - `StallCnt` increments on every cycle with `StallF` asserted.
  - `FlushCnt` increments on every `PCSrcE` flush.
  - `FwdCnt` increments on every cycle with a nonzero select on either operand.
  - All counters wrap modulo 2^CNT_W.

## Timing
- **Reset:** on a clock edge with `rst` = 1:
  - FSM goes to RUN; `bub_cnt` and all counters go to 0.
  - While `rst` is high, every stall, flush and forward output is forced to 0.
  - A reset that arrives during LU_STALL or MEM_WAIT abandons the operation with no residual stall.
- **Forwarding latency:** 0 cycles (combinational).
- **Load-use latency:** the first bubble is asserted in the detection cycle. Exactly `LOAD_BUBBLES` consecutive cycles carry `StallF` & `FlushE`, unless memory-wait cycles are interleaved.
- **Branch flush:** exactly one cycle, coincident with `PCSrcE`.
- **MEM_WAIT:** lasts from the first cycle with `MemReqM` & !`MemAckM` through the `MemAckM` cycle inclusive.
- **Counters:** update at the clock edge following the counted cycle.

## Configuration
- `HAZARD_PERF_CNT_EN`:
  - Defined: the three counters and their logic are built.
  - Undefined: `StallCnt`, `FlushCnt` and `FwdCnt` are tied to 0, and no counter flops exist. All other behaviour is identical.

## Test plan
- Forward M over W: `Rs1_E`=5, `RD_M`=5 and `RD_W`=5 with both write enables set -> `ForwardAE`=10. Clear `RegWriteM` -> `ForwardAE`=01. Set `RD_M`=`RD_W`=0 -> 00.
- Load-use with `LOAD_BUBBLES`=3: `ResultSrcE`=1, `RD_E`=7, `Rs2_D`=7 -> `StallF`/`StallD`/`FlushE` high for exactly 3 cycles, then RUN. `StallCnt` increases by 3.
- Branch beats load-use: `PCSrcE`=1 in the same cycle as `lu_hit` -> `FlushD`=`FlushE`=1 for one cycle, no stall, `FlushCnt`+1.
- Memory wait inside load-use: `LOAD_BUBBLES`=2; `MemReqM`=1 with `MemAckM`=0 for 4 cycles starting in the second bubble -> all four stalls high through the ack cycle, then 1 remaining load-use bubble.
- Reset mid-stall: assert `rst` during MEM_WAIT -> the next cycle has all outputs 0, the FSM is in RUN and the counters are 0.
- Counter wrap with `CNT_W`=4: 17 consecutive stall cycles -> `StallCnt`=1. With `HAZARD_PERF_CNT_EN` undefined -> the counters stay at 0.
